// File: rtl/ps2_key_event_queue_if.sv
// Handshake bundle between a PS/2 byte receiver, the key event queue and its consumer.
interface ps2_key_event_queue_if #(
  parameter int ADDR_W = 4
);
  logic              valid_scan;
  logic [7:0]        scan_code;
  logic              rd_en;
  logic              clr_ovf;
  logic              ev_valid;
  logic [7:0]        ev_code;
  logic              ev_ext;
  logic              ev_break;
  logic [ADDR_W:0]   ev_count;
  logic              full;
  logic              overflow;

  modport master (
    output valid_scan, scan_code, rd_en, clr_ovf,
    input  ev_valid, ev_code, ev_ext, ev_break, ev_count, full, overflow
  );

  modport slave (
    input  valid_scan, scan_code, rd_en, clr_ovf,
    output ev_valid, ev_code, ev_ext, ev_break, ev_count, full, overflow
  );
endinterface

// File: rtl/ps2_key_event_queue.sv
// PS/2 scan-code decoder (E0/F0 prefix stripping) feeding a show-ahead key event FIFO.
// Optional macro PS2_PREFIX_TIMEOUT_EN abandons a pending prefix after TIMEOUT_CYCLES idle cycles.
module ps2_key_event_queue #(
  parameter int DEPTH          = 16,
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  ps2_key_event_queue_if.slave  bus
);

  if (DEPTH != (1 << ADDR_W) || ADDR_W < 1 || ADDR_W > 8 || TIMEOUT_CYCLES < 1) begin : g_param_err
    $error("ps2_key_event_queue: DEPTH must equal 2**ADDR_W (2..256) and TIMEOUT_CYCLES >= 1");
  end

  // Bit 0 of the state marks a seen E0, bit 1 a seen F0, so prefixes can be OR-ed in.
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    PRE_E0   = 2'b01,
    PRE_F0   = 2'b10,
    PRE_E0F0 = 2'b11
  } state_t;

  state_t state, state_nxt;

  logic              push_req;
  logic              push_ext;
  logic              push_brk;
  logic              timeout_hit;
  logic              pop;
  logic              is_full;
  logic              do_write;
  logic              drop;
  logic [9:0]        mem [DEPTH];
  logic [9:0]        head;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              overflow_q;

  function automatic logic is_discard(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

`ifdef PS2_PREFIX_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] idle_cnt;

  assign timeout_hit = (state != IDLE) && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if (bus.valid_scan || state == IDLE || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    push_req  = 1'b0;
    push_ext  = state[0];
    push_brk  = state[1];
    if (bus.valid_scan) begin
      if (bus.scan_code == 8'hE0) begin
        state_nxt = state_t'(state | PRE_E0);
      end else if (bus.scan_code == 8'hF0) begin
        state_nxt = state_t'(state | PRE_F0);
      end else if (is_discard(bus.scan_code)) begin
        state_nxt = IDLE;
      end else begin
        push_req  = 1'b1;
        state_nxt = IDLE;
      end
    end else if (timeout_hit) begin
      state_nxt = IDLE;
    end
  end

  // A pop frees the slot the tail points at when full, so push+pop never drops.
  assign pop      = bus.rd_en && (count != '0);
  assign is_full  = (count == (ADDR_W + 1)'(DEPTH));
  assign do_write = push_req && (!is_full || pop);
  assign drop     = push_req && is_full && !pop;

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= {push_ext, push_brk, bus.scan_code};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_write, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (bus.clr_ovf) begin
      overflow_q <= 1'b0;
    end
  end

  assign head         = mem[rd_ptr];
  assign bus.ev_valid = (count != '0);
  assign bus.ev_code  = bus.ev_valid ? head[7:0] : 8'h00;
  assign bus.ev_ext   = bus.ev_valid & head[9];
  assign bus.ev_break = bus.ev_valid & head[8];
  assign bus.ev_count = count;
  assign bus.full     = is_full;
  assign bus.overflow = overflow_q;

endmodule
